// File: rtl/reset_key_conditioner_if.sv
// Board-side signal bundle for reset_key_conditioner: lock/keys/switch in, conditioned resets and keys out.
// The slave modport is the conditioner's view; the master modport is the board/core side.
interface reset_key_conditioner_if #(
  parameter int KEYS = 4
);
  logic            pll_locked;
  logic [KEYS-1:0] keys_n;
  logic            rst_key_invert;
  logic [KEYS-1:0] keys_db;
  logic [KEYS-1:0] key_press;
  logic [KEYS-1:0] key_release;
  logic            reset_out_n;
  logic            reset_active;

  modport master (
    output pll_locked, keys_n, rst_key_invert,
    input  keys_db, key_press, key_release, reset_out_n, reset_active
  );

  modport slave (
    input  pll_locked, keys_n, rst_key_invert,
    output keys_db, key_press, key_release, reset_out_n, reset_active
  );
endinterface

// File: rtl/reset_key_conditioner.sv
// Synchronises and debounces pushbuttons, and turns PLL lock plus a reset key into a
// stretched, cleanly released active-low core reset.
module reset_key_conditioner #(
  parameter int KEYS            = 4,
  parameter int DEBOUNCE_CYCLES = 625000,
  parameter int STRETCH_CYCLES  = 65536,
  parameter int RST_KEY         = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  reset_key_conditioner_if.slave  io
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int ST_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, STRETCH, RUN} state_t;

  logic [KEYS-1:0] key_meta_q, key_meta_d;
  logic [KEYS-1:0] key_s_q, key_s_d;
  logic            lock_meta_q, lock_meta_d;
  logic            lock_s_q, lock_s_d;
  logic [DB_W-1:0] db_cnt_q [KEYS];
  logic [DB_W-1:0] db_cnt_d [KEYS];
  logic [KEYS-1:0] keys_db_q, keys_db_d;
  logic [KEYS-1:0] press_q, press_d;
  logic [KEYS-1:0] release_q, release_d;
  state_t          state_q, state_d;
  logic [ST_W-1:0] st_cnt_q, st_cnt_d;
  logic            rst_n_q, rst_n_d;
  logic            active_q, active_d;
  logic            req;

  // Two-flop synchronisers feed per-key debounce counters; the counter restarts on any bounce.
  always_comb begin
    key_meta_d  = io.keys_n;
    key_s_d     = key_meta_q;
    lock_meta_d = io.pll_locked;
    lock_s_d    = lock_meta_q;
    keys_db_d   = keys_db_q;
    press_d     = '0;
    release_d   = '0;
    for (int i = 0; i < KEYS; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (key_s_q[i] == keys_db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] != DB_LAST) begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end else begin
        keys_db_d[i] = key_s_q[i];
        db_cnt_d[i]  = '0;
        press_d[i]   = ~key_s_q[i];
        release_d[i] = key_s_q[i];
      end
    end
  end

  // The invert switch is quasi-static, so it is used unsynchronised.
  assign req = ~lock_s_q | (~keys_db_q[RST_KEY] ^ io.rst_key_invert);

  always_comb begin
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    rst_n_d  = rst_n_q;
    unique case (state_q)
      HOLD: begin
        rst_n_d = 1'b0;
        if (!req) begin
          state_d  = STRETCH;
          st_cnt_d = '0;
        end
      end
      STRETCH: begin
        rst_n_d = 1'b0;
        if (req) begin
          state_d = HOLD;
        end else if (st_cnt_q == ST_LAST) begin
          state_d = RUN;
          rst_n_d = 1'b1;
        end else begin
          st_cnt_d = st_cnt_q + ST_W'(1);
        end
      end
      RUN: begin
        rst_n_d = 1'b1;
        if (req) begin
          state_d = HOLD;
          rst_n_d = 1'b0;
        end
      end
      default: begin
        state_d = HOLD;
        rst_n_d = 1'b0;
      end
    endcase
    active_d = ~rst_n_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta_q  <= '1;
      key_s_q     <= '1;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      for (int i = 0; i < KEYS; i++) db_cnt_q[i] <= '0;
      keys_db_q   <= '1;
      press_q     <= '0;
      release_q   <= '0;
      state_q     <= HOLD;
      st_cnt_q    <= '0;
      rst_n_q     <= 1'b0;
      active_q    <= 1'b1;
    end else begin
      key_meta_q  <= key_meta_d;
      key_s_q     <= key_s_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      for (int i = 0; i < KEYS; i++) db_cnt_q[i] <= db_cnt_d[i];
      keys_db_q   <= keys_db_d;
      press_q     <= press_d;
      release_q   <= release_d;
      state_q     <= state_d;
      st_cnt_q    <= st_cnt_d;
      rst_n_q     <= rst_n_d;
      active_q    <= active_d;
    end
  end

  assign io.keys_db      = keys_db_q;
  assign io.key_press    = press_q;
  assign io.key_release  = release_q;
  assign io.reset_out_n  = rst_n_q;
  assign io.reset_active = active_q;

endmodule
